// File: rtl/mpc_fetch.sv
// Program store plus in-order replay sequencer for the mpc add/sub/inc/dec stage.
// Instructions are presented over a valid/ready handshake, one per cycle when ready.
module mpc_fetch #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ADDR0   = '0;

    logic [IW-1:0] mem [DEPTH];

    state_t        state, state_d;
    logic [IW-1:0] instr_d;
    logic          vld_d, done_d;
    logic [AW-1:0] pc_d, pc_inc;
    logic [AW:0]   cnt, cnt_d, len_q, len_d, len_clamp;
    logic          fire, last, fwd;

    assign busy      = (state == RUN);
    assign pc_inc    = pc + AW'(1);
    assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
    assign fire      = instr_valid & instr_ready;
    assign last      = (cnt == len_q - (AW+1)'(1));
    assign fwd       = wr_en & (wr_addr == ADDR0);

    // Program array: no reset so the contents survive rst_n; writes locked out during replay
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        state_d = state;
        instr_d = instr_out;
        vld_d   = instr_valid;
        pc_d    = pc;
        cnt_d   = cnt;
        len_d   = len_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            if (state != IDLE)
                pc_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            vld_d   = 1'b1;
                            pc_d    = '0;
                            cnt_d   = '0;
                            len_d   = len_clamp;
                            // write-first: a same-edge write to word 0 is what gets presented
                            instr_d = fwd ? wr_data : mem[ADDR0];
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (last) begin
                            state_d = FINISH;
                            vld_d   = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            pc_d    = pc_inc;
                            cnt_d   = cnt + (AW+1)'(1);
                            instr_d = mem[pc_inc];
                        end
                    end
                end
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            cnt         <= '0;
            len_q       <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            instr_out   <= instr_d;
            instr_valid <= vld_d;
            pc          <= pc_d;
            cnt         <= cnt_d;
            len_q       <= len_d;
            done        <= done_d;
        end
    end
endmodule

// File: tb/tb_mpc_fetch.sv
// Self-checking bench for mpc_fetch: table-driven replays, hand-written corner
// sequences and randomized replays against a transaction-level program model.
module tb_mpc_fetch;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [IW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    mpc_fetch #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .abort(abort), .instr_out(instr_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } xfer_t;

    typedef struct {
        logic [AW:0] len;
        int          mode;
        int          exp_n;
        int          exp_last;
    } vec_t;

    int            n_tests = 0;
    int            n_fail = 0;
    logic [IW-1:0] ref_mem [DEPTH];
    xfer_t         got [$];
    xfer_t         x;
    int            done_cnt = 0;
    int            vld_cycles = 0;
    int            cyc = 0;
    int            last_xfer_cyc = 0;
    int            done_cyc = 0;
    bit            prev_stall = 0;
    bit            prev_abort = 0;
    bit            prev_done = 0;
    logic [IW-1:0] prev_out = '0;
    logic [AW-1:0] prev_pc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] mpc_ref(input logic [IW-1:0] w);
        case (w[17:16])
            2'b00:   return {1'b0, w[7:0]} + {1'b0, w[15:8]};
            2'b01:   return {1'b0, w[7:0]} - {1'b0, w[15:8]};
            2'b10:   return {1'b0, w[7:0]} + 9'd1;
            default: return {1'b0, w[7:0]} - 9'd1;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && !prev_abort) begin
                check("stall_valid", instr_valid, 1);
                check("stall_out", instr_out, prev_out);
                check("stall_pc", pc, prev_pc);
            end
            if (instr_valid) vld_cycles++;
            if (instr_valid && instr_ready) begin
                x.pc = pc;
                x.instr = instr_out;
                got.push_back(x);
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_busy", busy, 0);
                check("done_valid", instr_valid, 0);
                if (prev_done) check("done_width", 2, 1);
            end
        end
        prev_stall = rst_n && instr_valid && !instr_ready;
        prev_abort = abort;
        prev_done  = rst_n && done;
        prev_out   = instr_out;
        prev_pc    = pc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // mode 0: always ready, 1: random ready, 2: three stall cycles at pc=1
    task automatic run_replay(input logic [AW:0] l, input int mode, input bit fwd,
                              input logic [IW-1:0] fwd_word, input bit junk,
                              input int exp_n, input int exp_last, input string tag);
        int base_done, n, stalls, budget;
        got.delete();
        vld_cycles = 0;
        base_done = done_cnt;
        stalls = 0;
        n = (int'(l) > DEPTH) ? DEPTH : int'(l);
        instr_ready = (mode == 0);
        start = 1'b1;
        len = l;
        if (fwd) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = fwd_word;
            ref_mem[0] = fwd_word;
        end
        step();
        start = 1'b0;
        wr_en = 1'b0;
        if (n != 0) begin
            check({tag, "_lat_valid"}, instr_valid, 1);
            check({tag, "_lat_pc"}, pc, 0);
            check({tag, "_lat_busy"}, busy, 1);
            check({tag, "_lat_instr"}, instr_out, ref_mem[0]);
        end
        budget = 0;
        while (done_cnt == base_done && budget < 400) begin
            case (mode)
                0: instr_ready = 1'b1;
                1: instr_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (instr_valid && pc == 1 && stalls < 3) begin
                        instr_ready = 1'b0;
                        stalls++;
                    end else begin
                        instr_ready = 1'b1;
                    end
                end
            endcase
            if (junk && busy) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = 18'($urandom);
            end else begin
                wr_en = 1'b0;
            end
            step();
            budget++;
        end
        wr_en = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        check({tag, "_done_pulses"}, done_cnt - base_done, 1);
        check({tag, "_count"}, got.size(), n);
        check({tag, "_count_tbl"}, got.size(), exp_n);
        for (int i = 0; i < got.size() && i < n; i++) begin
            check({tag, "_pc"}, got[i].pc, i);
            check({tag, "_instr"}, got[i].instr, ref_mem[i]);
        end
        if (exp_n > 0 && got.size() > 0)
            check({tag, "_last_pc"}, got[got.size()-1].pc, exp_last);
        if (mode == 0) check({tag, "_valid_cycles"}, vld_cycles, n);
        if (mode == 0 && n > 0) check({tag, "_done_timing"}, done_cyc, last_xfer_cyc + 1);
        if (mode == 2 && n >= 2) check({tag, "_stalls"}, stalls, 3);
    endtask

    vec_t tbl [7];

    initial begin
        int base, b, nw, l, m, en;
        logic [IW-1:0] w1_orig;

        tbl[0] = '{5'd4,  0, 4,  3};
        tbl[1] = '{5'd0,  0, 0,  0};
        tbl[2] = '{5'd20, 0, 16, 15};
        tbl[3] = '{5'd16, 1, 16, 15};
        tbl[4] = '{5'd1,  0, 1,  0};
        tbl[5] = '{5'd31, 1, 16, 15};
        tbl[6] = '{5'd4,  2, 4,  3};

        step(); step();
        check("rst_instr", instr_out, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 18'($urandom));
        write_word(4'd0, {2'b00, 8'h72, 8'h8B});
        write_word(4'd1, {2'b01, 8'h07, 8'h20});
        write_word(4'd2, {2'b10, 8'h00, 8'h8B});
        write_word(4'd3, {2'b11, 8'h00, 8'h8B});
        w1_orig = ref_mem[1];

        run_replay(5'd4, 0, 0, '0, 0, 4, 3, "prog4");
        if (got.size() == 4) begin
            check("mpc0", mpc_ref(got[0].instr), 9'h0FD);
            check("mpc1", mpc_ref(got[1].instr), 9'h019);
            check("mpc2", mpc_ref(got[2].instr), 9'h08C);
            check("mpc3", mpc_ref(got[3].instr), 9'h08A);
        end else begin
            check("mpc_xfers", got.size(), 4);
        end

        for (int i = 0; i < 7; i++)
            run_replay(tbl[i].len, tbl[i].mode, 0, '0, 0, tbl[i].exp_n, tbl[i].exp_last, "tbl");

        // Abort mid-replay, then abort together with start while idle
        got.delete();
        base = done_cnt;
        instr_ready = 1'b1; start = 1'b1; len = 5'd8;
        step();
        start = 1'b0;
        b = 0;
        while (!(instr_valid && pc == 2) && b < 50) begin step(); b++; end
        check("abort_reach_pc2", b < 50, 1);
        abort = 1'b1; start = 1'b1; len = 5'd4; instr_ready = 1'b0;
        step();
        abort = 1'b0; start = 1'b0;
        check("abort_valid", instr_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_pc", pc, 0);
        step(); step(); step();
        check("abort_still_idle", instr_valid, 0);
        check("abort_no_done", done_cnt, base);
        check("abort_xfers", got.size(), 2);
        abort = 1'b1; start = 1'b1; len = 5'd4;
        step();
        abort = 1'b0; start = 1'b0;
        check("abort_start_valid", instr_valid, 0);
        check("abort_start_busy", busy, 0);
        step();
        check("abort_start_idle", instr_valid, 0);
        check("abort_start_no_done", done_cnt, base);

        // Writes during a replay are dropped; a write to word 0 on the start edge is forwarded
        run_replay(5'd4, 0, 0, '0, 1, 4, 3, "junkwr");
        run_replay(5'd4, 0, 0, '0, 0, 4, 3, "after_junk");
        check("word1_kept", ref_mem[1], w1_orig);
        run_replay(5'd4, 0, 1, 18'h2A5C3, 0, 4, 3, "fwd");

        // Asynchronous reset in the middle of a replay
        base = done_cnt;
        instr_ready = 1'b1; start = 1'b1; len = 5'd8;
        step();
        start = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_instr", instr_out, 0);
        check("arst_valid", instr_valid, 0);
        check("arst_pc", pc, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        instr_ready = 1'b0;
        step(); step();
        check("arst_no_done", done_cnt, base);
        run_replay(5'd8, 0, 0, '0, 0, 8, 7, "post_rst");

        // Randomized replays against the program model
        for (int k = 0; k < 25; k++) begin
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) write_word(AW'($urandom_range(0, DEPTH-1)), 18'($urandom));
            l = $urandom_range(0, 31);
            m = $urandom_range(0, 2);
            en = (l > DEPTH) ? DEPTH : l;
            run_replay(5'(l), m, ($urandom_range(0, 3) == 0), 18'($urandom), 0, en, en - 1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
